seq_tracker: RTL

- Receive-side counterpart of the digit-sequence output decoder.
- Consumes the 4-bit digit stream that decoder drives and recovers the sequence position and lock status from it.
  - Sequence: index 0..8 = 7, 9, 0, 6, 4, 6, 5, 3, 2.
  - Terminator: 4'b1111.
- Sits at the display/observer side of the lab datapath and flags stream errors and end-of-sequence for the top level.

---
 rtl/seq_tracker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_tracker.sv
// seq_tracker: recovers sequence position and lock status from the decoder digit stream.
// Optional saturating error counter enabled by defining SEQ_TRACKER_ERRCNT_EN.
module seq_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       d_valid,
    input  logic [3:0] d,
    input  logic       dir,
    output logic       locked,
    output logic [3:0] idx,
    output logic       err,
    output logic       done,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, LOCKED, DONE} state_t;

    localparam logic [3:0] TERM = 4'd15;

    state_t     state;
    logic [8:0] cand;
    logic [8:0] m_d;
    logic [8:0] shifted;
    logic [8:0] n_hunt;
    logic [3:0] n_pos;
    logic [3:0] exp_idx;
    logic       step_ok;
    logic       term_ok;
    logic       mis;

    function automatic logic [3:0] seq_val(input logic [3:0] i);
        case (i)
            4'd0:    seq_val = 4'd7;
            4'd1:    seq_val = 4'd9;
            4'd2:    seq_val = 4'd0;
            4'd3:    seq_val = 4'd6;
            4'd4:    seq_val = 4'd4;
            4'd5:    seq_val = 4'd6;
            4'd6:    seq_val = 4'd5;
            4'd7:    seq_val = 4'd3;
            4'd8:    seq_val = 4'd2;
            default: seq_val = TERM;
        endcase
    endfunction

    function automatic logic [8:0] match(input logic [3:0] v);
        logic [8:0] m;
        m = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            m[i] = (seq_val(i[3:0]) == v);
        end
        return m;
    endfunction

    always_comb begin
        m_d     = match(d);
        shifted = dir ? {cand[0], cand[8:1]} : {cand[7:0], cand[8]};
        n_hunt  = (cand == '0) ? m_d : (shifted & m_d);
        // Lost track entirely: restart the candidate set from this digit alone.
        if (n_hunt == '0) begin
            n_hunt = m_d;
        end
        n_pos = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (n_hunt[i]) begin
                n_pos = i[3:0];
            end
        end
        if (dir) begin
            exp_idx = (idx == 4'd0) ? 4'd8 : idx - 4'd1;
        end else begin
            exp_idx = (idx == 4'd8) ? 4'd0 : idx + 4'd1;
        end
        step_ok = (d == seq_val(exp_idx));
        term_ok = (d == TERM) && (dir ? (idx == 4'd0) : (idx == 4'd8));
        mis     = !clr && d_valid && (state == LOCKED) && !step_ok && !term_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            cand   <= '0;
            locked <= 1'b0;
            idx    <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (clr) begin
                state  <= HUNT;
                cand   <= '0;
                locked <= 1'b0;
                done   <= 1'b0;
            end else if (d_valid) begin
                case (state)
                    HUNT: begin
                        cand <= n_hunt;
                        if ($countones(n_hunt) == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            idx    <= n_pos;
                        end
                    end
                    LOCKED: begin
                        if (step_ok) begin
                            idx <= exp_idx;
                        end else if (term_ok) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            locked <= 1'b0;
                        end else begin
                            state  <= HUNT;
                            cand   <= m_d;
                            locked <= 1'b0;
                            err    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SEQ_TRACKER_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (mis && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule
